m32_8_serializer: RTL

//  Upstream companion of the 8->32 packer in the PHY datapath.
//  - Accepts 32-bit words over a valid/ready handshake into a small FIFO.
//  - Replays each word as four consecutive bytes at byte rate (clk_4f domain).
//  - Provides lane/first-byte markers so the downstream packer can realign.
//  - Single clock; no clock crossing inside.

---
 rtl/m32_8_serializer.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/m32_8_serializer.sv
// -----------------------------------------------------------------------------
// m32_8_serializer
//
// Word-to-byte serializer that sits upstream of the 8->32 packer in the PHY
// datapath. 32-bit words arrive over a valid/ready handshake into a small
// FIFO. Each word is then replayed as four consecutive bytes at byte rate,
// with lane and first-byte markers so the downstream packer can realign.
// Single clock domain (clk_4f); everything happens on its rising edge.
//
// Parameters:
//   FIFO_DEPTH  words of input buffering (power of two, >= 2)
//   MSB_FIRST   1: bytes [31:24],[23:16],[15:8],[7:0]; 0: reverse order
//   IDLE_BYTE   value driven on o_data_out whenever o_valid_out is low
//
// Ports:
//   i_clk_4f      byte-rate clock
//   i_reset       synchronous, active-high; drops partial and buffered words
//   i_data_in     input word
//   i_valid_in    i_data_in is valid
//   o_ready_in    a word can be accepted this cycle
//   o_data_out    current byte (registered)
//   o_valid_out   o_data_out is valid (registered)
//   i_ready_out   downstream consumes the byte this cycle
//   o_byte_lane   index of the byte on o_data_out, 0 = first byte of a word
//   o_first_byte  o_valid_out & (o_byte_lane == 0)
// -----------------------------------------------------------------------------
module m32_8_serializer #(
  parameter int         FIFO_DEPTH = 2,
  parameter int         MSB_FIRST  = 1,
  parameter logic [7:0] IDLE_BYTE  = 8'h00
) (
  input  logic        i_clk_4f,
  input  logic        i_reset,
  input  logic [31:0] i_data_in,
  input  logic        i_valid_in,
  output logic        o_ready_in,
  output logic [7:0]  o_data_out,
  output logic        o_valid_out,
  input  logic        i_ready_out,
  output logic [1:0]  o_byte_lane,
  output logic        o_first_byte
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

  typedef enum logic {
    S_EMPTY,
    S_EMIT
  } state_t;

  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  state_t        r_state;
  logic [31:0]   r_word;
  logic [1:0]    r_lane;
  logic [7:0]    r_data;

  state_t        w_state_nxt;
  logic [31:0]   w_word_nxt;
  logic [1:0]    w_lane_nxt;
  logic [7:0]    w_data_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_empty;
  logic [31:0]   w_head;

  // Picks the byte emitted at a given lane, honouring the configured order.
  function automatic logic [7:0] f_byte(input logic [31:0] word, input logic [1:0] lane);
    logic [1:0] pos;
    pos = (MSB_FIRST != 0) ? (2'd3 - lane) : lane;
    case (pos)
      2'd0:    f_byte = word[7:0];
      2'd1:    f_byte = word[15:8];
      2'd2:    f_byte = word[23:16];
      default: f_byte = word[31:24];
    endcase
  endfunction

  // Full is decided from the registered count only, so a pop on the same
  // edge never lets a word in while the FIFO is full.
  assign o_ready_in   = (r_count != FULL_COUNT);
  assign w_push       = i_valid_in & o_ready_in & ~i_reset;
  assign w_fifo_empty = (r_count == '0);
  assign w_head       = r_mem[r_rd_ptr];

  // FIFO storage needs no reset: the pointers and count define what is valid.
  always_ff @(posedge i_clk_4f) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data_in;
    end
  end

  // FIFO bookkeeping. Pointers wrap naturally because the depth is a power
  // of two; a simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge i_clk_4f) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output-side state register: the shift register word, lane and the
  // registered byte presented downstream.
  always_ff @(posedge i_clk_4f) begin
    if (i_reset) begin
      r_state <= S_EMPTY;
      r_word  <= '0;
      r_lane  <= 2'd0;
      r_data  <= IDLE_BYTE;
    end else begin
      r_state <= w_state_nxt;
      r_word  <= w_word_nxt;
      r_lane  <= w_lane_nxt;
      r_data  <= w_data_nxt;
    end
  end

  // Output-side next state. The shift register reloads from the FIFO head
  // either when it is empty or when its last byte is being consumed, so
  // back-to-back words stream with no bubble. When nothing is waiting after
  // the last byte, the output returns to idle.
  always_comb begin
    w_state_nxt = r_state;
    w_word_nxt  = r_word;
    w_lane_nxt  = r_lane;
    w_data_nxt  = r_data;
    w_pop       = 1'b0;

    case (r_state)
      S_EMPTY: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_EMIT;
          w_word_nxt  = w_head;
          w_lane_nxt  = 2'd0;
          w_data_nxt  = f_byte(w_head, 2'd0);
        end
      end
      default: begin
        if (i_ready_out) begin
          if (r_lane != 2'd3) begin
            w_lane_nxt = r_lane + 2'd1;
            w_data_nxt = f_byte(r_word, r_lane + 2'd1);
          end else if (!w_fifo_empty) begin
            w_pop       = 1'b1;
            w_word_nxt  = w_head;
            w_lane_nxt  = 2'd0;
            w_data_nxt  = f_byte(w_head, 2'd0);
          end else begin
            w_state_nxt = S_EMPTY;
            w_lane_nxt  = 2'd0;
            w_data_nxt  = IDLE_BYTE;
          end
        end
      end
    endcase
  end

  assign o_valid_out  = (r_state == S_EMIT);
  assign o_data_out   = r_data;
  assign o_byte_lane  = r_lane;
  assign o_first_byte = o_valid_out & (r_lane == 2'd0);

endmodule
